// File: rtl/pc_fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | pc_fetch_unit: fetch PC, 1-cycle sync imem, branch/stall/halt, decode IF  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module pc_fetch_unit #(
  parameter int                  PC_WIDTH    = 16,
  parameter int                  INST_WIDTH  = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int                  PC_STEP     = 2,
  parameter bit                  USE_EXT_INC = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [PC_WIDTH-1:0]   pc_out,
  input  logic [PC_WIDTH-1:0]   inc_pc,
  input  logic                  branch_en,
  input  logic [PC_WIDTH-1:0]   branch_target,
  input  logic                  halt,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic [INST_WIDTH-1:0] inst_out,
  output logic [PC_WIDTH-1:0]   inst_pc,
  output logic                  inst_valid,
  input  logic                  dec_ready,
  output logic                  halted
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [PC_WIDTH-1:0]   req_pc_q, req_pc_d;
  logic                  req_valid_q, req_valid_d;
  logic                  w_stall;
  logic [PC_WIDTH-1:0]   w_nxt_pc;

  generate
    if (USE_EXT_INC) begin : g_ext_inc
      assign w_nxt_pc = inc_pc;
    end else begin : g_int_inc
      logic w_unused_inc_pc;
      assign w_unused_inc_pc = ^inc_pc;
      assign w_nxt_pc        = pc_q + PC_WIDTH'(PC_STEP);
    end
  endgenerate

  assign w_stall    = req_valid_q && !dec_ready;
  // While stalled, re-read the held address so imem_rdata keeps the held word.
  assign imem_addr  = w_stall ? req_pc_q : pc_q;
  assign pc_out     = pc_q;
  assign inst_pc    = req_pc_q;
  assign inst_valid = req_valid_q;
  assign inst_out   = imem_rdata;
  assign halted     = (state_q == S_HALT) && !req_valid_q;

  always_comb begin
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    req_valid_d = req_valid_q;
    state_d     = state_q;
    if (branch_en) begin
      pc_d        = branch_target;
      req_valid_d = 1'b0;
      state_d     = S_RUN;
    end else if (w_stall) begin
      // hold everything until decode takes the presented instruction
    end else if (halt) begin
      req_valid_d = 1'b0;
      state_d     = S_HALT;
    end else begin
      req_pc_d    = pc_q;
      req_valid_d = 1'b1;
      pc_d        = w_nxt_pc;
      state_d     = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      req_valid_q <= 1'b0;
      state_q     <= S_BOOT;
    end else begin
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
      state_q     <= state_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_pc_fetch_unit: scoreboard bench for three pc_fetch_unit configurations |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_pc_fetch_unit;
  localparam int PW = 16;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          branch_en = 1'b0;
  logic          halt = 1'b0;
  logic          dec_ready = 1'b1;
  logic [PW-1:0] branch_target = '0;

  logic [PW-1:0] pc_out_a    [3];
  logic [PW-1:0] inc_pc_a    [3];
  logic [PW-1:0] imem_addr_a [3];
  logic [IW-1:0] imem_rdata_a[3];
  logic [IW-1:0] inst_out_a  [3];
  logic [PW-1:0] inst_pc_a   [3];
  logic          inst_valid_a[3];
  logic          halted_a    [3];

  logic [1:0]    sel = 2'd0;
  logic          mon_en = 1'b0;
  int            n_tests = 0;
  int            n_fail = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] mon_exp;

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] mem_word(input logic [PW-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC35A;
  endfunction

  // Synchronous instruction memory and external incrementer per instance.
  always @(posedge clk)
    for (int k = 0; k < 3; k++) imem_rdata_a[k] <= mem_word(imem_addr_a[k]);

  assign inc_pc_a[0] = pc_out_a[0] + 16'd2;
  assign inc_pc_a[1] = pc_out_a[1] + 16'd2;
  assign inc_pc_a[2] = pc_out_a[2] + 16'd2;

  pc_fetch_unit #(.PC_WIDTH(PW), .INST_WIDTH(IW), .RESET_PC(16'h0000), .PC_STEP(2), .USE_EXT_INC(1'b1)) u_ext (
    .clk(clk), .reset(reset), .pc_out(pc_out_a[0]), .inc_pc(inc_pc_a[0]),
    .branch_en(branch_en), .branch_target(branch_target), .halt(halt),
    .imem_addr(imem_addr_a[0]), .imem_rdata(imem_rdata_a[0]), .inst_out(inst_out_a[0]),
    .inst_pc(inst_pc_a[0]), .inst_valid(inst_valid_a[0]), .dec_ready(dec_ready), .halted(halted_a[0]));

  pc_fetch_unit #(.PC_WIDTH(PW), .INST_WIDTH(IW), .RESET_PC(16'h0000), .PC_STEP(2), .USE_EXT_INC(1'b0)) u_int (
    .clk(clk), .reset(reset), .pc_out(pc_out_a[1]), .inc_pc(inc_pc_a[1]),
    .branch_en(branch_en), .branch_target(branch_target), .halt(halt),
    .imem_addr(imem_addr_a[1]), .imem_rdata(imem_rdata_a[1]), .inst_out(inst_out_a[1]),
    .inst_pc(inst_pc_a[1]), .inst_valid(inst_valid_a[1]), .dec_ready(dec_ready), .halted(halted_a[1]));

  pc_fetch_unit #(.PC_WIDTH(PW), .INST_WIDTH(IW), .RESET_PC(16'hFFFC), .PC_STEP(2), .USE_EXT_INC(1'b1)) u_wrap (
    .clk(clk), .reset(reset), .pc_out(pc_out_a[2]), .inc_pc(inc_pc_a[2]),
    .branch_en(branch_en), .branch_target(branch_target), .halt(halt),
    .imem_addr(imem_addr_a[2]), .imem_rdata(imem_rdata_a[2]), .inst_out(inst_out_a[2]),
    .inst_pc(inst_pc_a[2]), .inst_valid(inst_valid_a[2]), .dec_ready(dec_ready), .halted(halted_a[2]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (dut %0d): got %h expected %h", tag, sel, got, exp);
    end
  endtask

  // A redirect squashes whatever decode sees in the same cycle.
  always @(negedge clk) begin
    if (mon_en && !reset && dec_ready && !branch_en && inst_valid_a[sel]) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_inst", {16'h0, inst_pc_a[sel]}, 32'hFFFF_FFFF);
      end else begin
        mon_exp = exp_q.pop_front();
        check_eq("inst_pc", {16'h0, inst_pc_a[sel]}, {16'h0, mon_exp});
        check_eq("inst_out", {16'h0, inst_out_a[sel]}, {16'h0, mem_word(mon_exp)});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_inst(input logic [PW-1:0] pc);
    bit hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      tick();
      if (inst_valid_a[sel] && inst_pc_a[sel] == pc) hit = 1'b1;
    end
    check_eq("wait_inst", {15'h0, inst_valid_a[sel], inst_pc_a[sel]}, {15'h0, 1'b1, pc});
  endtask

  task automatic wait_pcout(input logic [PW-1:0] pc);
    bit hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      tick();
      if (pc_out_a[sel] == pc) hit = 1'b1;
    end
    check_eq("wait_pcout", {16'h0, pc_out_a[sel]}, {16'h0, pc});
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    check_eq("drain", exp_q.size(), 0);
    mon_en = 1'b0;
  endtask

  task automatic do_reset(input logic [PW-1:0] rp);
    mon_en = 1'b0;
    reset = 1'b1; branch_en = 1'b0; halt = 1'b0; dec_ready = 1'b1;
    exp_q.delete();
    tick();
    tick();
    check_eq("rst_pc_out", {16'h0, pc_out_a[sel]}, {16'h0, rp});
    check_eq("rst_valid", {31'h0, inst_valid_a[sel]}, 32'h0);
    check_eq("rst_halted", {31'h0, halted_a[sel]}, 32'h0);
    reset = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic run_main();
    do_reset(16'h0000);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0002);
    exp_q.push_back(16'h0004); exp_q.push_back(16'h0006);
    // Decode back-pressure on inst_pc=4.
    wait_inst(16'h0004);
    dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_pc", {16'h0, inst_pc_a[sel]}, 32'h4);
      check_eq("stall_valid", {31'h0, inst_valid_a[sel]}, 32'h1);
      check_eq("stall_inst", {16'h0, inst_out_a[sel]}, {16'h0, mem_word(16'h0004)});
      check_eq("stall_addr", {16'h0, imem_addr_a[sel]}, 32'h4);
    end
    dec_ready = 1'b1;
    // Redirect while inst_pc=8 is presented: 8 is dropped.
    wait_inst(16'h0008);
    branch_en = 1'b1; branch_target = 16'h0100;
    tick();
    branch_en = 1'b0;
    check_eq("redirect_flush", {31'h0, inst_valid_a[sel]}, 32'h0);
    exp_q.push_back(16'h0100); exp_q.push_back(16'h0102);
    tick();
    check_eq("redirect_latency", {15'h0, inst_valid_a[sel], inst_pc_a[sel]}, {15'h0, 1'b1, 16'h0100});
    // Redirect plus halt during a stall: held inst flushed, branch wins.
    wait_inst(16'h0104);
    dec_ready = 1'b0;
    tick();
    check_eq("stall_hold_104", {16'h0, inst_pc_a[sel]}, 32'h104);
    branch_en = 1'b1; halt = 1'b1; branch_target = 16'h001C;
    tick();
    check_eq("brhalt_valid", {31'h0, inst_valid_a[sel]}, 32'h0);
    check_eq("brhalt_halted", {31'h0, halted_a[sel]}, 32'h0);
    check_eq("brhalt_pc", {16'h0, pc_out_a[sel]}, 32'h1C);
    branch_en = 1'b0; halt = 1'b0; dec_ready = 1'b1;
    exp_q.push_back(16'h001C); exp_q.push_back(16'h001E);
    exp_q.push_back(16'h0020); exp_q.push_back(16'h0022);
    // Halt at pc 0x20, then release.
    wait_pcout(16'h0020);
    halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("halt_valid", {31'h0, inst_valid_a[sel]}, 32'h0);
      check_eq("halt_halted", {31'h0, halted_a[sel]}, 32'h1);
      check_eq("halt_pc_out", {16'h0, pc_out_a[sel]}, 32'h20);
    end
    halt = 1'b0;
    wait_inst(16'h0022);
    // Mid-stream reset.
    tick();
    reset = 1'b1;
    tick();
    check_eq("midrst_valid", {31'h0, inst_valid_a[sel]}, 32'h0);
    check_eq("midrst_pc_out", {16'h0, pc_out_a[sel]}, 32'h0);
    check_eq("midrst_halted", {31'h0, halted_a[sel]}, 32'h0);
    check_eq("midrst_queue", exp_q.size(), 0);
    reset = 1'b0;
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0002);
    wait_drain();
  endtask

  initial begin
    sel = 2'd0;
    run_main();
    sel = 2'd1;
    run_main();
    sel = 2'd2;
    do_reset(16'hFFFC);
    exp_q.push_back(16'hFFFC); exp_q.push_back(16'hFFFE);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0002);
    wait_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
`default_nettype wire
